br_reslv_queue: RTL
===================

BR_RESLV_QUEUE -- requirements
Module: br_reslv_queue

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 8, giving the number of in-flight branch slots (power of two, at least 2).
REQ-002 The block SHALL have parameter BHR_W, default 4, giving the branch-history width, equal to the predictor BHR width.
REQ-003 The block SHALL have parameter BR_STATE_W, default 2, giving the resolution code width; encodings are BR_NONE=2'b00, BR_PR_CORRECT=2'b01, BR_PR_WRONG=2'b10.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alloc_i  input  1  dispatch of one branch this cycle.
REQ-007 pred_i  input  1  predicted direction from the predictor (1 = taken).
REQ-008 bhr_i  input  BHR_W  BHR snapshot saved by the predictor for this branch.
REQ-009 alloc_tag_o  output  log2(ENTRIES)  slot index assigned to the current alloc_i (the tail index).
REQ-010 full_o  output  1  high when count == ENTRIES.
REQ-011 ex_valid_i  input  1  execute stage resolved one branch this cycle.
REQ-012 ex_tag_i  input  log2(ENTRIES)  slot of the resolved branch.
REQ-013 ex_taken_i  input  1  actual direction.
REQ-014 reslv_o  output  BR_STATE_W  resolution code to the predictor; registered.
REQ-015 taken_o  output  1  actual direction of the retired branch; registered.
REQ-016 recrv_bhr_o  output  BHR_W  BHR snapshot of the retired branch; registered.
REQ-017 flush_o  output  1  one-cycle pulse, registered, concurrent with reslv_o == BR_PR_WRONG.

Function
REQ-018 Storage: circular buffer; head and tail pointers of log2(ENTRIES)+1 bits, with the MSB used as wrap bit; count = tail - head.
REQ-019 Per-entry state: valid, resolved, pred, taken, bhr.
REQ-020 Allocation when alloc_i && !full_o: write {valid=1, resolved=0, pred_i, bhr_i} at the tail index, then tail+1; alloc_tag_o = tail index, combinational.
REQ-021 Allocation when alloc_i && full_o: ignored; no state change.
REQ-022 Resolution when ex_valid_i and entry[ex_tag_i].valid && !resolved: set resolved=1 and taken=ex_taken_i.
REQ-023 Resolution when ex_valid_i targets an invalid or already-resolved entry: ignored.
REQ-024 Retirement is in order only: on a clock edge where entry[head] is valid && resolved, the block SHALL register:
  - reslv_o = BR_PR_CORRECT if taken == pred, else BR_PR_WRONG;
  - taken_o = entry taken;
  - recrv_bhr_o = entry bhr;
  - flush_o = (taken != pred).
REQ-025 On that same retirement edge the block SHALL clear the head entry valid bit and advance head by 1.
REQ-026 At most one branch SHALL retire per cycle.
REQ-027 reslv_o SHALL be BR_NONE and flush_o 0 in every cycle without a retirement; taken_o and recrv_bhr_o hold their previous values.
REQ-028 Latency: ex_valid_i for the head entry in cycle N gives a visible reslv_o in cycle N+2; a younger resolved entry retires only after all older entries retire.
REQ-029 Mispredict retire: the block SHALL clear all valid bits and set tail = head+1 (queue empty) on the same edge; any alloc_i or ex_valid_i in that cycle is discarded.
REQ-030 Alloc and non-mispredict retire in the same cycle SHALL both take effect; when the queue is full, alloc is still refused by REQ-021, since full_o reflects pre-edge state.
REQ-031 ex_valid_i on the current head in the same cycle as retirement of a different entry is impossible by construction; ex_valid_i on a newly allocated tag in its allocation cycle is ignored.
REQ-032 Pointer wrap: index = ptr[log2(ENTRIES)-1:0]; full when indices are equal and wrap bits differ; empty when pointers are equal.

Reset
REQ-033 On rst the block SHALL set head = tail = 0 and clear all valid and resolved bits.
REQ-034 On rst the block SHALL drive reslv_o = BR_NONE, taken_o = 0, recrv_bhr_o = 0, flush_o = 0.
REQ-035 On rst, alloc_tag_o = 0 and full_o = 0 in the following cycle.
REQ-036 rst SHALL override alloc, resolve and retire events in the same cycle; mid-operation reset discards all entries without a retirement pulse.

Verification
REQ-037 Correct prediction: alloc pred=1, bhr=4'b1010 (tag 0), then ex tag 0 taken=1 in cycle N -> cycle N+2 reslv_o=01, taken_o=1, recrv_bhr_o=1010, flush_o=0; cycle N+3 reslv_o=00.
REQ-038 Out-of-order resolve: alloc tags 0,1,2; resolve 2, then 1, then 0 (all correct) -> three consecutive retire cycles in order carrying bhr of tags 0,1,2, with no retirement before tag 0 resolves.
REQ-039 Mispredict flush: alloc tags 0..3; tag 1 already resolved; tag 0 resolves pred=0, taken=1, bhr=0011 -> reslv_o=10, flush_o=1, taken_o=1, recrv_bhr_o=0011; queue then empty, tag 1 never retires, next alloc_tag_o=1.
REQ-040 Full and wrap: 8 allocs -> full_o=1; 9th alloc ignored; retire one, alloc one -> alloc_tag_o=0 with wrap bit set, full_o=1 again.
REQ-041 Simultaneous events: mispredict retire coincident with alloc_i and ex_valid_i -> both discarded, count=0 afterwards.
REQ-042 Reset mid-operation: 5 entries with 2 resolved, assert rst for 1 cycle -> no reslv_o pulse, full_o=0, alloc_tag_o=0.

Source files
------------

// File: rtl/br_reslv_queue_if.sv
// br_reslv_queue_if: dispatch/execute/retire bundle between the pipeline and the branch resolution queue.
interface br_reslv_queue_if #(
  parameter int ENTRIES    = 8,
  parameter int BHR_W      = 4,
  parameter int BR_STATE_W = 2
);
  localparam int IW = $clog2(ENTRIES);
  logic                  alloc_i;
  logic                  pred_i;
  logic [BHR_W-1:0]      bhr_i;
  logic [IW-1:0]         alloc_tag_o;
  logic                  full_o;
  logic                  ex_valid_i;
  logic [IW-1:0]         ex_tag_i;
  logic                  ex_taken_i;
  logic [BR_STATE_W-1:0] reslv_o;
  logic                  taken_o;
  logic [BHR_W-1:0]      recrv_bhr_o;
  logic                  flush_o;
  modport master (
    output alloc_i, pred_i, bhr_i, ex_valid_i, ex_tag_i, ex_taken_i,
    input  alloc_tag_o, full_o, reslv_o, taken_o, recrv_bhr_o, flush_o
  );
  modport slave (
    input  alloc_i, pred_i, bhr_i, ex_valid_i, ex_tag_i, ex_taken_i,
    output alloc_tag_o, full_o, reslv_o, taken_o, recrv_bhr_o, flush_o
  );
endinterface

// File: rtl/br_reslv_queue.sv
// br_reslv_queue: in-order branch retirement queue with out-of-order resolution and mispredict flush.
module br_reslv_queue #(
  parameter int ENTRIES    = 8,
  parameter int BHR_W      = 4,
  parameter int BR_STATE_W = 2
) (
  input logic             clk,
  input logic             rst,
  br_reslv_queue_if.slave q
);
  localparam int IW = $clog2(ENTRIES);
  localparam logic [BR_STATE_W-1:0] BR_NONE       = BR_STATE_W'(0);
  localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = BR_STATE_W'(1);
  localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = BR_STATE_W'(2);
  logic [IW:0]             head_q, head_d, tail_q, tail_d;
  logic [ENTRIES-1:0]      valid_q, valid_d, resolved_q, resolved_d, pred_q, pred_d, taken_q, taken_d;
  logic [BHR_W-1:0]        bhr_q [ENTRIES];
  logic [BHR_W-1:0]        bhr_d [ENTRIES];
  logic [BR_STATE_W-1:0]   reslv_q, reslv_d;
  logic                    taken_out_q, taken_out_d, flush_q, flush_d;
  logic [BHR_W-1:0]        rbhr_q, rbhr_d;
  logic [IW-1:0]           head_idx, tail_idx;
  logic                    full, retire, mispred, do_alloc, do_res;
  assign head_idx      = head_q[IW-1:0];
  assign tail_idx      = tail_q[IW-1:0];
  assign full          = (head_q[IW] != tail_q[IW]) && (head_idx == tail_idx);
  assign retire        = valid_q[head_idx] && resolved_q[head_idx];
  assign mispred       = retire && (taken_q[head_idx] != pred_q[head_idx]);
  assign do_alloc      = q.alloc_i && !full && !mispred;
  assign do_res        = q.ex_valid_i && valid_q[q.ex_tag_i] && !resolved_q[q.ex_tag_i] && !mispred;
  assign q.alloc_tag_o = tail_idx;
  assign q.full_o      = full;
  assign q.reslv_o     = reslv_q;
  assign q.taken_o     = taken_out_q;
  assign q.recrv_bhr_o = rbhr_q;
  assign q.flush_o     = flush_q;
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    pred_d      = pred_q;
    taken_d     = taken_q;
    bhr_d       = bhr_q;
    reslv_d     = retire ? (mispred ? BR_PR_WRONG : BR_PR_CORRECT) : BR_NONE;
    flush_d     = mispred;
    taken_out_d = retire ? taken_q[head_idx] : taken_out_q;
    rbhr_d      = retire ? bhr_q[head_idx] : rbhr_q;
    if (do_res) begin
      resolved_d[q.ex_tag_i] = 1'b1;
      taken_d[q.ex_tag_i]    = q.ex_taken_i;
    end
    if (retire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + 1'b1;
    end
    if (do_alloc) begin
      valid_d[tail_idx]    = 1'b1;
      resolved_d[tail_idx] = 1'b0;
      pred_d[tail_idx]     = q.pred_i;
      bhr_d[tail_idx]      = q.bhr_i;
      tail_d               = tail_q + 1'b1;
    end
    // a wrong-path retire empties the queue right behind the retiring entry
    if (mispred) begin
      valid_d = '0;
      tail_d  = head_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      resolved_q  <= '0;
      pred_q      <= '0;
      taken_q     <= '0;
      bhr_q       <= '{default: '0};
      reslv_q     <= BR_NONE;
      taken_out_q <= 1'b0;
      rbhr_q      <= '0;
      flush_q     <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      pred_q      <= pred_d;
      taken_q     <= taken_d;
      bhr_q       <= bhr_d;
      reslv_q     <= reslv_d;
      taken_out_q <= taken_out_d;
      rbhr_q      <= rbhr_d;
      flush_q     <= flush_d;
    end
  end
endmodule
